// File: rtl/fifo_read_stream_adapter_if.sv
// Read-side bus bundle for fifo_read_stream_adapter: FIFO read handshake
// (fifo_empty / fifo_rdata / fifo_r_en) plus the outgoing valid/ready stream.
// The master modport is taken by the adapter, the slave modport by its environment.
interface fifo_read_stream_adapter_if #(
    parameter int DSIZE = 8
);
    logic             fifo_empty;
    logic [DSIZE-1:0] fifo_rdata;
    logic             fifo_r_en;
    logic             m_valid;
    logic [DSIZE-1:0] m_data;
    logic             m_ready;

    modport master (
        input  fifo_empty,
        input  fifo_rdata,
        input  m_ready,
        output fifo_r_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_rdata,
        output m_ready,
        input  fifo_r_en,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/fifo_read_stream_adapter.sv
// Read-domain consumer for the async FIFO. Issues reads against a credit of
// three (buffer occupancy plus the read in flight), captures the registered
// FIFO read data one rclk later into a 3-entry circular prefetch buffer and
// presents the buffer head as a valid/ready stream. fifo_r_en depends only on
// fifo_empty and registered state, never on m_ready.
// Optional feature macro: RD_LEVEL_EN adds g_wptr_sync/g_rptr inputs and a
// registered rd_level output (words held in FIFO memory).
module fifo_read_stream_adapter #(
    parameter int DSIZE    = 8,
    parameter int PTRWIDTH = 3,
    parameter int CNTWIDTH = 16
) (
    input  logic                         rclk,
    input  logic                         rrst_n,
    fifo_read_stream_adapter_if.master   bus,
    output logic [CNTWIDTH-1:0]          rd_count
`ifdef RD_LEVEL_EN
    ,
    input  logic [PTRWIDTH:0]            g_wptr_sync,
    input  logic [PTRWIDTH:0]            g_rptr,
    output logic [PTRWIDTH:0]            rd_level
`endif
);

    logic [1:0]          r_occ;
    logic [1:0]          r_head;
    logic [1:0]          r_tail;
    logic                r_inflight;
    logic [DSIZE-1:0]    r_buf [0:2];
    logic [CNTWIDTH-1:0] r_count;

    logic [2:0]          w_credit;
    logic                w_rd_en;
    logic                w_pop;
    logic                w_valid;

    function automatic logic [1:0] f_inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Read credit, stream handshake and read request (held low during reset)
    always_comb begin
        w_credit = {1'b0, r_occ} + {2'b00, r_inflight};
        w_valid  = (r_occ != 2'd0);
        w_pop    = w_valid & bus.m_ready;
        w_rd_en  = rrst_n & ~bus.fifo_empty & (w_credit < 3'd3);
    end

    assign bus.fifo_r_en = w_rd_en;
    assign bus.m_valid   = w_valid;
    assign bus.m_data    = r_buf[r_head];
    assign rd_count      = r_count;

    // Prefetch buffer: capture in-flight word at tail, advance head on pop
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_occ      <= 2'd0;
            r_head     <= 2'd0;
            r_tail     <= 2'd0;
            r_inflight <= 1'b0;
            r_count    <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_inflight <= w_rd_en;
            if (r_inflight) begin
                r_buf[r_tail] <= bus.fifo_rdata;
                r_tail        <= f_inc3(r_tail);
            end
            if (w_pop) begin
                r_head  <= f_inc3(r_head);
                r_count <= r_count + 1'b1;
            end
            r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

`ifdef RD_LEVEL_EN
    logic [PTRWIDTH:0] w_wbin;
    logic [PTRWIDTH:0] w_rbin;
    logic [PTRWIDTH:0] r_level;

    // Binary value is the XOR of the gray code with all its right shifts
    function automatic logic [PTRWIDTH:0] f_gray2bin(input logic [PTRWIDTH:0] g);
        logic [PTRWIDTH:0] b;
        b = g;
        for (int unsigned i = 1; i <= PTRWIDTH; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    // Pointer conversion for the level difference
    always_comb begin
        w_wbin = f_gray2bin(g_wptr_sync);
        w_rbin = f_gray2bin(g_rptr);
    end

    // Registered FIFO fill level, modulo pointer width
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_level <= '0;
        end else begin
            r_level <= w_wbin - w_rbin;
        end
    end

    assign rd_level = r_level;
`endif

endmodule
